spi_image_rx: RTL
=================

// Module: spi_image_rx
// PURPOSE
//  SPI mode-0 slave receiver that feeds the system controller with one binarised OCR image per frame.
//  Oversamples SCLK/COPI/spi_cs_n in the clk domain and assembles bytes MSB-first into a flat image vector.
//  Presents the vector with a valid/ack handshake; the controller's send_image drives rx_enable.
// PARAMETERS
//  IMG_BITS     784  image size in bits (28x28); must be a multiple of 8
//  SYNC_STAGES  2    flop stages on SCLK, COPI and spi_cs_n; min 2
// PORTS
//  clk          in   1         system clock; must run at >= 4x SCLK
//  rst          in   1         synchronous, active-high reset
//  SCLK         in   1         SPI clock, async to clk
//  COPI         in   1         SPI data in, async to clk
//  spi_cs_n     in   1         SPI chip select, active low, async to clk
//  rx_enable    in   1         controller permits reception; bytes arriving while low are dropped
//  img_bits     out  IMG_BITS  assembled image; bit k = k-th bit received in the frame
//  img_valid    out  1         image complete and stable
//  img_ack      in   1         controller consumed image; sampled only while img_valid=1
//  byte_count   out  $clog2(IMG_BITS/8+1)  bytes stored in the current frame
//  overrun_err  out  1         sticky; set on a byte received in FULL or with rx_enable=0
//  chk_err      out  1         sticky; checksum mismatch (SPI_RX_CHECKSUM_EN only, else tied 0)
// BEHAVIOUR
//  - Reset: all outputs 0, img_bits all 0, state IDLE, synchronisers cleared (sync chains load 1 for cs_n).
//  - Sync: SYNC_STAGES flops per input; SCLK rise = synced SCLK prev 0, cur 1, while synced cs_n=0.
//  - On SCLK rise: shift synced COPI into 8-bit shift reg and increment 3-bit bit_cnt (bit_cnt wraps 7->0).
//  - Byte done: 1 clk after the 8th rise, write byte to img_bits[8*byte_count +: 8], first-received bit at lowest index; byte_count++.
//  - States: IDLE -> RECV on cs_n falling (synced); RECV -> FULL when byte_count reaches IMG_BITS/8;
//    RECV -> IDLE on cs_n rising before full (frame aborted: bit_cnt and byte_count cleared, img_bits kept);
//    FULL: img_valid=1; on img_ack=1 -> IDLE next clk, img_valid=0, byte_count=0.
//  - Partial byte at cs_n rise discarded; in FULL, cs_n rise has no effect (image held until ack).
//  - Bytes completing in FULL or while rx_enable=0: not stored, overrun_err<=1; cleared only by rst.
//  - img_ack while img_valid=0 ignored. img_bits stable for the whole time img_valid=1.
//  - Latency: img_valid rises 1 clk after the last byte write (SYNC_STAGES+2 clks after the final SCLK rise).
//  - rst mid-frame: immediate return to IDLE; the next frame needs a fresh cs_n falling edge.
// CONFIGURATION
//  SPI_RX_CHECKSUM_EN defined: one extra byte follows the image = XOR of all image bytes;
//   RECV waits in CHECK state for it; match -> FULL; mismatch -> chk_err<=1 (sticky), IDLE, img_valid stays 0.
//  Not defined: no checksum byte; RECV -> FULL directly; chk_err tied 0.
// STRUCTURE
//  Package spi_rx_pkg: typedef enum {IDLE, RECV, CHECK, FULL} rx_state_t; localparam BYTE_W=8;
//   default IMG_BITS, SYNC_STAGES.
//  Sub-module spi_rx_sync_edge: N-stage synchroniser + rise/fall pulse generator, instantiated for SCLK and cs_n;
//   COPI uses the same instance with edges unused.
// TESTING
//  1. Reset, then frame of 98 bytes 0x00..0x61 at clk/8 -> img_valid=1, byte_count=98, img_bits[7:0]=8'h00,
//     img_bits[15:8] holds bit-reversed 0x01 (img_bits[15]=1).
//  2. Assert img_ack for 1 clk -> img_valid=0 next clk, byte_count=0; second frame of 0xFF bytes -> img_bits all 1.
//  3. cs_n high after 5 bits of byte 3 -> byte_count=3 then 0, state IDLE, no img_valid, overrun_err=0.
//  4. Extra byte 0xAA sent while FULL, or any byte sent with rx_enable=0 -> overrun_err=1, img_bits unchanged.
//  5. rst pulsed mid-frame at byte 40 -> all outputs 0 next clk; fresh full frame then completes normally.
//  6. SPI_RX_CHECKSUM_EN: correct XOR byte -> img_valid=1; corrupted XOR byte -> chk_err=1, img_valid=0.

Source files
------------

// File: rtl/spi_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_rx_pkg
//  Description : Shared types and constants for the SPI image receiver.
//                Optional build macro used by the receiver: SPI_RX_CHECKSUM_EN
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_rx_pkg;

    localparam int BYTE_W              = 8;
    localparam int IMG_BITS_DEFAULT    = 784;
    localparam int SYNC_STAGES_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2,
        FULL  = 2'd3
    } rx_state_t;

    // Bytes arrive MSB-first but the image wants the first received bit at the
    // lowest index, so every stored byte is bit-reversed.
    function automatic logic [BYTE_W-1:0] bit_rev8(input logic [BYTE_W-1:0] b);
        logic [BYTE_W-1:0] r;
        for (int i = 0; i < BYTE_W; i++) begin
            r[i] = b[BYTE_W-1-i];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_image_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_image_rx_if
//  Description : Image handshake between the SPI receiver (slave modport) and
//                the system controller (master modport).
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_image_rx_if #(
    parameter int IMG_BITS = 784
);
    localparam int CNT_W = $clog2(IMG_BITS / 8 + 1);

    logic                rx_enable;
    logic [IMG_BITS-1:0] img_bits;
    logic                img_valid;
    logic                img_ack;
    logic [CNT_W-1:0]    byte_count;
    logic                overrun_err;
    logic                chk_err;

    modport slave (
        input  rx_enable,
        input  img_ack,
        output img_bits,
        output img_valid,
        output byte_count,
        output overrun_err,
        output chk_err
    );

    modport master (
        output rx_enable,
        output img_ack,
        input  img_bits,
        input  img_valid,
        input  byte_count,
        input  overrun_err,
        input  chk_err
    );

endinterface
`default_nettype wire

// File: rtl/spi_rx_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : spi_rx_sync_edge
//  Description : N-stage synchroniser for an asynchronous input with single
//                clk rise/fall pulses derived from the synchronised level.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_rx_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_chain;
    logic              r_prev;

    // Shift the async input through the chain; keep the previous synced level for edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= {STAGES{RESET_VAL}};
            r_prev  <= RESET_VAL;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_async};
            r_prev  <= r_chain[STAGES-1];
        end
    end

    assign o_sync = r_chain[STAGES-1];
    assign o_rise = r_chain[STAGES-1] & ~r_prev;
    assign o_fall = ~r_chain[STAGES-1] & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_image_rx.sv
`default_nettype none
// ============================================================================
//  Module      : spi_image_rx
//  Description : SPI mode-0 slave that assembles one binarised image per frame
//                and hands it to the controller with a valid/ack handshake.
//                Build macro SPI_RX_CHECKSUM_EN: expect a trailing XOR byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_image_rx
    import spi_rx_pkg::*;
#(
    parameter int IMG_BITS    = IMG_BITS_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          SCLK,
    input  logic          COPI,
    input  logic          spi_cs_n,
    spi_image_rx_if.slave img
);

    localparam int               IMG_BYTES  = IMG_BITS / BYTE_W;
    localparam int               CNT_W      = $clog2(IMG_BYTES + 1);
    localparam logic [CNT_W-1:0] C_FULL_CNT = CNT_W'(IMG_BYTES);

    logic w_sclk_rise, w_sclk_unused_fall, w_sclk_unused_lvl;
    logic w_cs_sync, w_cs_rise, w_cs_fall;
    logic w_copi_sync, w_copi_unused_rise, w_copi_unused_fall;

    spi_rx_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk    (clk),
        .rst    (rst),
        .i_async(SCLK),
        .o_sync (w_sclk_unused_lvl),
        .o_rise (w_sclk_rise),
        .o_fall (w_sclk_unused_fall)
    );

    spi_rx_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk    (clk),
        .rst    (rst),
        .i_async(spi_cs_n),
        .o_sync (w_cs_sync),
        .o_rise (w_cs_rise),
        .o_fall (w_cs_fall)
    );

    spi_rx_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk    (clk),
        .rst    (rst),
        .i_async(COPI),
        .o_sync (w_copi_sync),
        .o_rise (w_copi_unused_rise),
        .o_fall (w_copi_unused_fall)
    );

    rx_state_t             r_state, w_next;
    logic [BYTE_W-1:0]     r_shift;
    logic [2:0]            r_bit_cnt;
    logic                  r_byte_done;
    logic [CNT_W-1:0]      r_byte_count;
    logic [IMG_BITS-1:0]   r_img_bits;
    logic                  r_overrun;
    logic                  w_bit_rise, w_full_reached, w_store, w_overrun, w_clear;
    logic [CNT_W+2:0]      w_wr_base;
`ifdef SPI_RX_CHECKSUM_EN
    logic [BYTE_W-1:0]     r_xor;
    logic                  r_chk_err;
    logic                  w_chk_byte, w_chk_ok;
`endif

    assign w_bit_rise     = w_sclk_rise & ~w_cs_sync;
    assign w_full_reached = (r_byte_count == C_FULL_CNT);
    assign w_wr_base      = {r_byte_count, 3'b000};

    // Bit assembly: shift on each SCLK rise inside the frame, drop partial bytes at cs_n edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_byte_done <= 1'b0;
        end else begin
            r_byte_done <= 1'b0;
            if (w_cs_rise || w_cs_fall) begin
                r_bit_cnt <= '0;
            end else if (w_bit_rise) begin
                r_shift   <= {r_shift[BYTE_W-2:0], w_copi_sync};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_byte_done <= 1'b1;
                end
            end
        end
    end

    // Decide what a completed byte does: store it, flag it as overrun, or treat it as checksum.
    always_comb begin
        w_store   = 1'b0;
        w_overrun = 1'b0;
`ifdef SPI_RX_CHECKSUM_EN
        w_chk_byte = 1'b0;
        w_chk_ok   = (r_shift == r_xor);
`endif
        if (r_byte_done) begin
            if (!img.rx_enable || r_state == FULL) begin
                w_overrun = 1'b1;
            end else if (r_state == RECV && !w_full_reached) begin
                w_store = 1'b1;
            end
`ifdef SPI_RX_CHECKSUM_EN
            else if (r_state == CHECK) begin
                w_chk_byte = 1'b1;
            end
`endif
        end
    end

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Frame sequencing: start on cs_n fall, abort on cs_n rise, hold the image until ack.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_cs_fall) w_next = RECV;
            end
            RECV: begin
                if (w_cs_rise) begin
                    w_next = IDLE;
                end else if (w_full_reached) begin
`ifdef SPI_RX_CHECKSUM_EN
                    w_next = CHECK;
`else
                    w_next = FULL;
`endif
                end
            end
            CHECK: begin
`ifdef SPI_RX_CHECKSUM_EN
                if (w_cs_rise) begin
                    w_next = IDLE;
                end else if (w_chk_byte) begin
                    w_next = w_chk_ok ? FULL : IDLE;
                end
`else
                w_next = IDLE;
`endif
            end
            FULL: begin
                if (img.img_ack) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Any return to IDLE, or the start of a new frame, restarts the byte count.
    assign w_clear = ((w_next == IDLE) && (r_state != IDLE)) || ((r_state == IDLE) && w_cs_fall);

    // Image storage, byte counter and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_count <= '0;
            r_img_bits   <= '0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_clear) begin
                r_byte_count <= '0;
            end else if (w_store) begin
                r_byte_count <= r_byte_count + CNT_W'(1);
            end
            if (w_store) begin
                r_img_bits[w_wr_base +: BYTE_W] <= bit_rev8(r_shift);
            end
            if (w_overrun) begin
                r_overrun <= 1'b1;
            end
        end
    end

`ifdef SPI_RX_CHECKSUM_EN
    // Running XOR of stored bytes and sticky checksum error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_xor     <= '0;
            r_chk_err <= 1'b0;
        end else begin
            if (w_clear && !w_chk_byte) begin
                r_xor <= '0;
            end else if (w_store) begin
                r_xor <= r_xor ^ r_shift;
            end
            if (w_chk_byte && !w_chk_ok) begin
                r_chk_err <= 1'b1;
            end
        end
    end
    assign img.chk_err = r_chk_err;
`else
    assign img.chk_err = 1'b0;
`endif

    assign img.img_bits    = r_img_bits;
    assign img.img_valid   = (r_state == FULL);
    assign img.byte_count  = r_byte_count;
    assign img.overrun_err = r_overrun;

endmodule
`default_nettype wire
